rename_rat: RTL

- Register alias table that produces the per-source rename results consumed by the decode register/rename pipeline stage: src0/src1 valid flags and ROB tags.
- Holds, for each architectural register, whether a younger in-flight producer exists and which ROB entry it occupies.
- Updated by rename (allocate), commit (release) and pipeline flush (branch-correction or snoop hit).
- Sits beside the register file in decode. Its outputs pair with the register file read data.

---
 rtl/rename_rat_pkg.sv | 17 +
 rtl/rename_rat_lookup.sv | 27 ++
 rtl/rename_rat.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rename_rat_pkg.sv
// Shared constants and types for the register alias table.
package rename_rat_pkg;

    localparam int ARCH_REGS = 32;
    localparam int AREG_W    = 5;
    localparam int ROB_W     = 4;

    // r0 is hardwired zero and never has an in-flight producer
    localparam logic [AREG_W-1:0] REG_ZERO = '0;

    // One alias-table entry: is a producer in flight, and which ROB slot holds it
    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] rob;
    } rat_entry;

endpackage

// File: rtl/rename_rat_lookup.sv
// Alias-table read port: selects one entry, masks r0, and hides a producer
// that is retiring this very cycle (the register file forwards its result).
module rename_rat_lookup
    import rename_rat_pkg::*;
(
    input  logic [AREG_W-1:0]             src_addr,
    input  rat_entry [ARCH_REGS-1:0]      rat_table,
    input  logic                          commit_en,
    input  logic [AREG_W-1:0]             commit_dst,
    input  logic [ROB_W-1:0]              commit_rob,
    output logic                          src_valid,
    output logic [ROB_W-1:0]              src_rob
);

    rat_entry sel_entry;
    logic     commit_bypass;

    // Read mux with commit bypass; an invalid result always reports tag 0
    always_comb begin
        sel_entry     = rat_table[src_addr];
        commit_bypass = commit_en && (src_addr == commit_dst) &&
                        sel_entry.valid && (sel_entry.rob == commit_rob);
        src_valid     = sel_entry.valid && !commit_bypass && (src_addr != REG_ZERO);
        src_rob       = src_valid ? sel_entry.rob : '0;
    end

endmodule

// File: rtl/rename_rat.sv
// Register alias table: tracks the youngest in-flight producer of every
// architectural register. Rename allocates, commit releases a matching tag,
// flush clears everything. Lookups are combinational from the current table.
module rename_rat
    import rename_rat_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                snoop_hit,
    input  logic                bco_valid,
    input  logic [AREG_W-1:0]   i_src0_addr,
    input  logic [AREG_W-1:0]   i_src1_addr,
    output logic                o_rat_src0_valid,
    output logic [ROB_W-1:0]    o_rat_src0_rob,
    output logic                o_rat_src1_valid,
    output logic [ROB_W-1:0]    o_rat_src1_rob,
    input  logic                i_rename_en,
    input  logic [AREG_W-1:0]   i_rename_dst,
    input  logic [ROB_W-1:0]    i_rename_rob,
    input  logic                i_commit_en,
    input  logic [AREG_W-1:0]   i_commit_dst,
    input  logic [ROB_W-1:0]    i_commit_rob,
    output logic [AREG_W:0]     o_inflight_cnt
);

    rat_entry [ARCH_REGS-1:0] rat_table;
    logic                     flush;
    logic                     rename_valid;
    logic                     rename_new;
    logic                     commit_match;
    logic                     commit_dec;
    logic [AREG_W:0]          cnt_reg;
    logic [AREG_W:0]          cnt_next;

    assign flush = bco_valid || snoop_hit;

    // Per-register storage; only the valid bit is reset, tags are don't-care when invalid
    generate
        for (genvar gi = 0; gi < ARCH_REGS; gi++) begin : g_entry
            if (gi == 0) begin : g_zero
                assign rat_table[gi] = '0;
            end else begin : g_reg
                logic             valid_reg;
                logic             valid_next;
                logic [ROB_W-1:0] rob_reg;
                logic             rename_hit;
                logic             commit_hit;

                assign rename_hit = i_rename_en && (i_rename_dst == AREG_W'(gi));
                assign commit_hit = i_commit_en && (i_commit_dst == AREG_W'(gi)) &&
                                    valid_reg && (rob_reg == i_commit_rob);

                // Flush beats rename, rename beats a same-cycle commit
                always_comb begin
                    valid_next = valid_reg;
                    if (flush)
                        valid_next = 1'b0;
                    else if (rename_hit)
                        valid_next = 1'b1;
                    else if (commit_hit)
                        valid_next = 1'b0;
                end

                // Valid bit register, cleared asynchronously
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn)
                        valid_reg <= 1'b0;
                    else
                        valid_reg <= valid_next;
                end

                // Tag capture on rename; harmless during flush since valid drops
                always_ff @(posedge clk) begin
                    if (rename_hit)
                        rob_reg <= i_rename_rob;
                end

                assign rat_table[gi] = '{valid: valid_reg, rob: rob_reg};
            end
        end
    endgenerate

    // Incremental occupancy: +1 for a fresh mapping, -1 for a release not cancelled by a same-register rename
    always_comb begin
        rename_valid = i_rename_en && (i_rename_dst != REG_ZERO);
        rename_new   = rename_valid && !rat_table[i_rename_dst].valid;
        commit_match = i_commit_en && (i_commit_dst != REG_ZERO) &&
                       rat_table[i_commit_dst].valid &&
                       (rat_table[i_commit_dst].rob == i_commit_rob);
        commit_dec   = commit_match && !(rename_valid && (i_rename_dst == i_commit_dst));
        if (flush)
            cnt_next = '0;
        else
            cnt_next = cnt_reg + (AREG_W+1)'(rename_new) - (AREG_W+1)'(commit_dec);
    end

    // Occupancy counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end

    assign o_inflight_cnt = cnt_reg;

    rename_rat_lookup u_lookup_src0 (
        .src_addr   (i_src0_addr),
        .rat_table  (rat_table),
        .commit_en  (i_commit_en),
        .commit_dst (i_commit_dst),
        .commit_rob (i_commit_rob),
        .src_valid  (o_rat_src0_valid),
        .src_rob    (o_rat_src0_rob)
    );

    rename_rat_lookup u_lookup_src1 (
        .src_addr   (i_src1_addr),
        .rat_table  (rat_table),
        .commit_en  (i_commit_en),
        .commit_dst (i_commit_dst),
        .commit_rob (i_commit_rob),
        .src_valid  (o_rat_src1_valid),
        .src_rob    (o_rat_src1_rob)
    );

endmodule
